// File: rtl/mr_track_pkg.sv
// -----------------------------------------------------------------------------
// mr_track_pkg
// Shared types and helpers for the multi-rank mode-register transition tracker.
//   mrs_kind_e : kind of MRS command (normal, preamble training, gear-down, reserved)
//   cnt_max    : max-of-two for window counter values (operands zero-extended
//                to MAX_CNT_W by the caller, so any CNT_W up to 32 is supported)
// -----------------------------------------------------------------------------
package mr_track_pkg;

  typedef enum logic [1:0] {
    MRS_NORMAL   = 2'd0,
    MRS_PREAMBLE = 2'd1,
    MRS_GEARDOWN = 2'd2,
    MRS_RSVD     = 2'd3
  } mrs_kind_e;

  localparam int MAX_CNT_W = 32;

  function automatic logic [MAX_CNT_W-1:0] cnt_max(input logic [MAX_CNT_W-1:0] a,
                                                   input logic [MAX_CNT_W-1:0] b);
    logic [MAX_CNT_W-1:0] m;
    if (a > b) begin
      m = a;
    end else begin
      m = b;
    end
    return m;
  endfunction

endpackage

// File: rtl/mr_window_counter.sv
// -----------------------------------------------------------------------------
// mr_window_counter
// One saturating window counter. Each cycle the count decrements towards 0;
// on load it becomes max(decremented count, load_val), so a new load extends
// a running window but never shortens it. Because the load is a max() of two
// CNT_W values the counter can never wrap.
// Ports:
//   clk      : clock
//   rst      : synchronous active-high reset (count -> 0)
//   load     : load request this cycle
//   load_val : requested window length in clocks
//   active   : window running (count != 0), decoded from the register
// -----------------------------------------------------------------------------
module mr_window_counter
  import mr_track_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             active
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] dec_s;

  // Next count: saturating decrement, raised to load_val when a load arrives.
  always_comb begin
    if (cnt_q != {CNT_W{1'b0}}) begin
      dec_s = cnt_q - CNT_W'(1);
    end else begin
      dec_s = {CNT_W{1'b0}};
    end
    if (load) begin
      cnt_d = CNT_W'(cnt_max(MAX_CNT_W'(dec_s), MAX_CNT_W'(load_val)));
    end else begin
      cnt_d = dec_s;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign active = (cnt_q != {CNT_W{1'b0}});

endmodule

// File: rtl/mr_transition_tracker.sv
// -----------------------------------------------------------------------------
// mr_transition_tracker
// Tracks, per rank, the ODT-ignore window opened by every MRS command and the
// gear-down reset pulse / gear-down mode toggle produced by gear-down MRS.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   mrs_valid         : MRS command this cycle (no backpressure)
//   mrs_broadcast     : command targets all ranks (mrs_rank ignored)
//   mrs_rank          : target rank when not broadcast
//   mrs_kind          : NORMAL / PREAMBLE / GEARDOWN / RSVD
//   tmod_cycles       : tMOD window length, sampled only on mrs_valid
//   tsdo_cycles       : tSDO window length, sampled only on mrs_valid
//   tcmd_gear_cycles  : tCMD_GEAR pulse length, sampled only on mrs_valid
//   odt_ignore        : per-rank ODT-transition window active
//   gear_down_reset   : per-rank gear-down reset pulse
//   gear_down_mode    : per-rank current gear-down state
//   any_busy          : OR of odt_ignore and gear_down_reset
//   illegal_mrs       : sticky error (RSVD kind, bad rank, MRS in blackout)
// All outputs come from registers or decodes of registers only.
// -----------------------------------------------------------------------------
module mr_transition_tracker
  import mr_track_pkg::*;
#(
  parameter int NUM_RANKS = 4,
  parameter int CNT_W     = 8,
  parameter int RANK_W    = (NUM_RANKS > 1) ? $clog2(NUM_RANKS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mrs_valid,
  input  logic                 mrs_broadcast,
  input  logic [RANK_W-1:0]    mrs_rank,
  input  mrs_kind_e            mrs_kind,
  input  logic [CNT_W-1:0]     tmod_cycles,
  input  logic [CNT_W-1:0]     tsdo_cycles,
  input  logic [CNT_W-1:0]     tcmd_gear_cycles,
  output logic [NUM_RANKS-1:0] odt_ignore,
  output logic [NUM_RANKS-1:0] gear_down_reset,
  output logic [NUM_RANKS-1:0] gear_down_mode,
  output logic                 any_busy,
  output logic                 illegal_mrs
);

  logic [NUM_RANKS-1:0] target_s;
  logic [NUM_RANKS-1:0] oc_load_s;
  logic [NUM_RANKS-1:0] gc_load_s;
  logic [NUM_RANKS-1:0] gdm_q;
  logic [NUM_RANKS-1:0] gdm_d;
  logic [CNT_W-1:0]     win_len_s;
  logic                 kind_loads_s;
  logic                 kind_gear_s;
  logic                 kind_rsvd_s;
  logic                 rank_oob_s;
  logic                 blackout_hit_s;
  logic                 illegal_q;
  logic                 illegal_d;

  // Rank decode: an out-of-range rank matches no bit, which flags it as illegal.
  always_comb begin
    target_s = {NUM_RANKS{1'b0}};
    for (int r = 0; r < NUM_RANKS; r++) begin
      target_s[r] = mrs_broadcast | (mrs_rank == RANK_W'(r));
    end
    rank_oob_s = ~mrs_broadcast & ~(|target_s);
  end

  // Kind decode: window length and whether the gear counter is involved.
  always_comb begin
    win_len_s    = tmod_cycles;
    kind_loads_s = 1'b1;
    kind_gear_s  = 1'b0;
    kind_rsvd_s  = 1'b0;
    case (mrs_kind)
      MRS_NORMAL: begin
        win_len_s = tmod_cycles;
      end
      MRS_PREAMBLE: begin
        win_len_s = tsdo_cycles;
      end
      MRS_GEARDOWN: begin
        win_len_s   = tmod_cycles;
        kind_gear_s = 1'b1;
      end
      MRS_RSVD: begin
        kind_loads_s = 1'b0;
        kind_rsvd_s  = 1'b1;
      end
      default: begin
        kind_loads_s = 1'b0;
        kind_rsvd_s  = 1'b1;
      end
    endcase
  end

  // Per-rank load strobes, gear-mode toggle and sticky error next state.
  // The blackout check uses the gear counters' state before this edge, and
  // the offending command is still applied.
  always_comb begin
    oc_load_s      = target_s & {NUM_RANKS{mrs_valid & kind_loads_s}};
    gc_load_s      = target_s & {NUM_RANKS{mrs_valid & kind_gear_s}};
    blackout_hit_s = mrs_valid & (|(target_s & gear_down_reset));
    gdm_d          = gdm_q ^ gc_load_s;
    illegal_d      = illegal_q | (mrs_valid & (kind_rsvd_s | rank_oob_s)) | blackout_hit_s;
  end

  // Gear-down mode and error flag registers; reset wins over any MRS.
  always_ff @(posedge clk) begin
    if (rst) begin
      gdm_q     <= {NUM_RANKS{1'b0}};
      illegal_q <= 1'b0;
    end else begin
      gdm_q     <= gdm_d;
      illegal_q <= illegal_d;
    end
  end

  for (genvar r = 0; r < NUM_RANKS; r++) begin : g_rank
    mr_window_counter #(.CNT_W(CNT_W)) u_odt_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (oc_load_s[r]),
      .load_val (win_len_s),
      .active   (odt_ignore[r])
    );
    mr_window_counter #(.CNT_W(CNT_W)) u_gear_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (gc_load_s[r]),
      .load_val (tcmd_gear_cycles),
      .active   (gear_down_reset[r])
    );
  end

  assign gear_down_mode = gdm_q;
  assign illegal_mrs    = illegal_q;
  assign any_busy       = |(odt_ignore | gear_down_reset);

endmodule

// File: tb/tb_mr_transition_tracker.sv
// -----------------------------------------------------------------------------
// Self-checking bench for mr_transition_tracker. Two instances share stimulus:
// a 4-rank build and a 3-rank build (for the out-of-range rank case).
// The reference model keeps, per rank, the absolute clock edge at which each
// window ends; a new command can only push that end time later.
// -----------------------------------------------------------------------------
module tb_mr_transition_tracker;
  import mr_track_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       mrs_valid;
  logic       mrs_broadcast;
  logic [1:0] mrs_rank;
  mrs_kind_e  mrs_kind;
  logic [7:0] tmod;
  logic [7:0] tsdo;
  logic [7:0] tgear;

  logic [3:0] odt4, gdr4, gdm4;
  logic       busy4, ill4;
  logic [2:0] odt3, gdr3, gdm3;
  logic       busy3, ill3;

  always #5 clk = ~clk;

  mr_transition_tracker #(.NUM_RANKS(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .mrs_valid(mrs_valid), .mrs_broadcast(mrs_broadcast),
    .mrs_rank(mrs_rank), .mrs_kind(mrs_kind), .tmod_cycles(tmod),
    .tsdo_cycles(tsdo), .tcmd_gear_cycles(tgear), .odt_ignore(odt4),
    .gear_down_reset(gdr4), .gear_down_mode(gdm4), .any_busy(busy4),
    .illegal_mrs(ill4)
  );

  mr_transition_tracker #(.NUM_RANKS(3), .CNT_W(8)) dut3 (
    .clk(clk), .rst(rst), .mrs_valid(mrs_valid), .mrs_broadcast(mrs_broadcast),
    .mrs_rank(mrs_rank), .mrs_kind(mrs_kind), .tmod_cycles(tmod),
    .tsdo_cycles(tsdo), .tcmd_gear_cycles(tgear), .odt_ignore(odt3),
    .gear_down_reset(gdr3), .gear_down_mode(gdm3), .any_busy(busy3),
    .illegal_mrs(ill3)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // model state: [instance][rank], end edges are exclusive
  int         oend [2][4];
  int         gend [2][4];
  logic [3:0] mmode [2];
  logic       mill [2];

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s edge=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endfunction

  // apply the command rules for the edge just taken (edge number cyc)
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int nr;
      bit hit [4];
      nr = (i == 0) ? 4 : 3;
      if (rst) begin
        for (int r = 0; r < 4; r++) begin
          oend[i][r] = 0;
          gend[i][r] = 0;
        end
        mmode[i] = 4'b0;
        mill[i]  = 1'b0;
      end else if (mrs_valid) begin
        for (int r = 0; r < 4; r++)
          hit[r] = (r < nr) && (mrs_broadcast || int'(mrs_rank) == r);
        if (!mrs_broadcast && int'(mrs_rank) >= nr) mill[i] = 1'b1;
        if (mrs_kind == MRS_RSVD) mill[i] = 1'b1;
        // blackout: gear pulse still running as of the previous edge
        for (int r = 0; r < 4; r++)
          if (hit[r] && (cyc - 1) < gend[i][r]) mill[i] = 1'b1;
        for (int r = 0; r < 4; r++) begin
          if (hit[r]) begin
            case (mrs_kind)
              MRS_NORMAL:   oend[i][r] = imax(oend[i][r], cyc + int'(tmod));
              MRS_PREAMBLE: oend[i][r] = imax(oend[i][r], cyc + int'(tsdo));
              MRS_GEARDOWN: begin
                oend[i][r]  = imax(oend[i][r], cyc + int'(tmod));
                gend[i][r]  = imax(gend[i][r], cyc + int'(tgear));
                mmode[i][r] = ~mmode[i][r];
              end
              default: ;
            endcase
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [3:0] eo, eg;
    for (int i = 0; i < 2; i++) begin
      eo = 4'b0;
      eg = 4'b0;
      for (int r = 0; r < ((i == 0) ? 4 : 3); r++) begin
        eo[r] = (cyc < oend[i][r]);
        eg[r] = (cyc < gend[i][r]);
      end
      if (i == 0) begin
        chk("m4_odt",  {28'b0, odt4}, {28'b0, eo});
        chk("m4_gdr",  {28'b0, gdr4}, {28'b0, eg});
        chk("m4_gdm",  {28'b0, gdm4}, {28'b0, mmode[0]});
        chk("m4_busy", {31'b0, busy4}, {31'b0, (|(eo | eg))});
        chk("m4_ill",  {31'b0, ill4}, {31'b0, mill[0]});
      end else begin
        chk("m3_odt",  {29'b0, odt3}, {29'b0, eo[2:0]});
        chk("m3_gdr",  {29'b0, gdr3}, {29'b0, eg[2:0]});
        chk("m3_gdm",  {29'b0, gdm3}, {29'b0, mmode[1][2:0]});
        chk("m3_busy", {31'b0, busy3}, {31'b0, (|(eo[2:0] | eg[2:0]))});
        chk("m3_ill",  {31'b0, ill3}, {31'b0, mill[1]});
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    mrs_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic mrs(input mrs_kind_e k, input logic bc, input logic [1:0] rk);
    mrs_valid     = 1'b1;
    mrs_kind      = k;
    mrs_broadcast = bc;
    mrs_rank      = rk;
    tick();
    mrs_valid = 1'b0;
  endtask

  typedef struct {
    mrs_kind_e  kind;
    logic       bc;
    logic [1:0] rank;
    logic [7:0] tm;
    logic [7:0] ts;
    logic [7:0] tg;
    int         wait_n;
    logic [3:0] e_odt;
    logic [3:0] e_gdr;
    logic [3:0] e_gdm;
    logic       e_ill;
  } vec_t;

  vec_t vecs [9];

  initial begin
    rst = 1'b1; mrs_valid = 1'b0; mrs_broadcast = 1'b0; mrs_rank = 2'd0;
    mrs_kind = MRS_NORMAL; tmod = 8'd24; tsdo = 8'd40; tgear = 8'd8;

    // reset state
    do_reset();
    chk("rst_odt", {28'b0, odt4}, 32'h0);
    chk("rst_gdr", {28'b0, gdr4}, 32'h0);
    chk("rst_gdm", {28'b0, gdm4}, 32'h0);
    chk("rst_busy", {31'b0, busy4}, 32'h0);
    chk("rst_ill", {31'b0, ill4}, 32'h0);

    // single-command vectors: sample wait_n edges after the MRS edge
    vecs[0] = '{MRS_NORMAL,   1'b0, 2'd1, 8'd24, 8'd0,  8'd0,  0,  4'b0010, 4'b0000, 4'b0000, 1'b0};
    vecs[1] = '{MRS_NORMAL,   1'b0, 2'd1, 8'd24, 8'd0,  8'd0,  23, 4'b0010, 4'b0000, 4'b0000, 1'b0};
    vecs[2] = '{MRS_NORMAL,   1'b0, 2'd1, 8'd24, 8'd0,  8'd0,  24, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[3] = '{MRS_PREAMBLE, 1'b0, 2'd3, 8'd5,  8'd40, 8'd0,  39, 4'b1000, 4'b0000, 4'b0000, 1'b0};
    vecs[4] = '{MRS_GEARDOWN, 1'b1, 2'd0, 8'd24, 8'd0,  8'd8,  7,  4'b1111, 4'b1111, 4'b1111, 1'b0};
    vecs[5] = '{MRS_GEARDOWN, 1'b1, 2'd0, 8'd24, 8'd0,  8'd8,  8,  4'b1111, 4'b0000, 4'b1111, 1'b0};
    vecs[6] = '{MRS_RSVD,     1'b0, 2'd0, 8'd24, 8'd24, 8'd8,  0,  4'b0000, 4'b0000, 4'b0000, 1'b1};
    vecs[7] = '{MRS_NORMAL,   1'b0, 2'd2, 8'd0,  8'd0,  8'd0,  0,  4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[8] = '{MRS_GEARDOWN, 1'b0, 2'd0, 8'd3,  8'd0,  8'd10, 5,  4'b0000, 4'b0001, 4'b0001, 1'b0};

    for (int v = 0; v < 9; v++) begin
      do_reset();
      tmod = vecs[v].tm; tsdo = vecs[v].ts; tgear = vecs[v].tg;
      mrs(vecs[v].kind, vecs[v].bc, vecs[v].rank);
      idle(vecs[v].wait_n);
      chk($sformatf("vec%0d_odt", v), {28'b0, odt4}, {28'b0, vecs[v].e_odt});
      chk($sformatf("vec%0d_gdr", v), {28'b0, gdr4}, {28'b0, vecs[v].e_gdr});
      chk($sformatf("vec%0d_gdm", v), {28'b0, gdm4}, {28'b0, vecs[v].e_gdm});
      chk($sformatf("vec%0d_ill", v), {31'b0, ill4}, {31'b0, vecs[v].e_ill});
    end

    // window extension, never shortened
    do_reset();
    tmod = 8'd24; tsdo = 8'd40;
    mrs(MRS_NORMAL, 1'b0, 2'd0);
    idle(9);
    mrs(MRS_PREAMBLE, 1'b0, 2'd0);
    idle(9);
    tmod = 8'd5;
    mrs(MRS_NORMAL, 1'b0, 2'd0);
    idle(29);
    chk("ext_last", {28'b0, odt4}, 32'h1);
    idle(1);
    chk("ext_end", {28'b0, odt4}, 32'h0);

    // broadcast gear-down twice
    do_reset();
    tmod = 8'd24; tgear = 8'd8;
    mrs(MRS_GEARDOWN, 1'b1, 2'd0);
    chk("gd_mode_on", {28'b0, gdm4}, 32'hf);
    chk("gd_rst_on", {28'b0, gdr4}, 32'hf);
    idle(7);
    chk("gd_rst_last", {28'b0, gdr4}, 32'hf);
    idle(1);
    chk("gd_rst_end", {28'b0, gdr4}, 32'h0);
    chk("gd_odt_mid", {28'b0, odt4}, 32'hf);
    idle(15);
    chk("gd_odt_last", {28'b0, odt4}, 32'hf);
    idle(1);
    chk("gd_odt_end", {28'b0, odt4}, 32'h0);
    idle(5);
    mrs(MRS_GEARDOWN, 1'b1, 2'd0);
    chk("gd_mode_off", {28'b0, gdm4}, 32'h0);
    chk("gd_no_ill", {31'b0, ill4}, 32'h0);

    // MRS inside gear-down blackout: flagged but still applied
    do_reset();
    tmod = 8'd24; tgear = 8'd8;
    mrs(MRS_GEARDOWN, 1'b0, 2'd2);
    idle(2);
    chk("bo_ill_before", {31'b0, ill4}, 32'h0);
    mrs(MRS_NORMAL, 1'b0, 2'd2);
    chk("bo_ill_set", {31'b0, ill4}, 32'h1);
    idle(23);
    chk("bo_ext_last", {28'b0, odt4}, 32'h4);
    idle(1);
    chk("bo_ext_end", {28'b0, odt4}, 32'h0);
    chk("bo_ill_sticky", {31'b0, ill4}, 32'h1);
    do_reset();
    chk("bo_ill_clr", {31'b0, ill4}, 32'h0);

    // out-of-range rank on the 3-rank build; zero-length window
    do_reset();
    tmod = 8'd24;
    mrs(MRS_NORMAL, 1'b0, 2'd3);
    chk("oob_odt3", {29'b0, odt3}, 32'h0);
    chk("oob_ill3", {31'b0, ill3}, 32'h1);
    chk("oob_odt4", {28'b0, odt4}, 32'h8);
    chk("oob_ill4", {31'b0, ill4}, 32'h0);
    do_reset();
    tmod = 8'd0;
    mrs(MRS_NORMAL, 1'b0, 2'd1);
    chk("zero_odt", {28'b0, odt4}, 32'h0);
    idle(2);
    chk("zero_odt_later", {28'b0, odt4}, 32'h0);

    // reset in the middle of a window with a same-cycle MRS
    do_reset();
    tmod = 8'd24;
    mrs(MRS_NORMAL, 1'b0, 2'd0);
    idle(4);
    rst = 1'b1; mrs_valid = 1'b1; mrs_kind = MRS_GEARDOWN; mrs_broadcast = 1'b0; mrs_rank = 2'd1;
    tick();
    rst = 1'b0; mrs_valid = 1'b0;
    chk("rstw_odt", {28'b0, odt4}, 32'h0);
    chk("rstw_gdm", {28'b0, gdm4}, 32'h0);
    chk("rstw_busy", {31'b0, busy4}, 32'h0);
    idle(2);
    chk("rstw_odt_later", {28'b0, odt4}, 32'h0);

    // random traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst           = ($urandom_range(0, 99) == 0);
      mrs_valid     = ($urandom_range(0, 3) == 0);
      mrs_broadcast = ($urandom_range(0, 7) == 0);
      mrs_rank      = 2'($urandom_range(0, 3));
      mrs_kind      = mrs_kind_e'($urandom_range(0, 3));
      tmod          = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 30));
      tsdo          = 8'($urandom_range(0, 50));
      tgear         = 8'($urandom_range(0, 12));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
